// File: rtl/stm_req_pkg.sv
// Shared state encoding and default timing constants for the STM request conditioner.
package stm_req_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StGap  = 2'd2
  } req_state_e;

  localparam int unsigned DefSyncStages  = 2;
  localparam int unsigned DefDebounceCyc = 16;
  localparam int unsigned DefMinGapCyc   = 200;

endpackage

// File: rtl/stm_sync_debounce.sv
// Brings the asynchronous STM trigger into the clock domain, debounces it and emits a
// registered one-cycle pulse on every accepted 0->1 transition.
module stm_sync_debounce
  import stm_req_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DbW-1:0]         r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // The level flips on the cycle after the counter has seen DEBOUNCE_CYC mismatches,
  // so a change must persist for DEBOUNCE_CYC + 1 synchronized samples.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_rise <= 1'b0;
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DbW'(DEBOUNCE_CYC)) begin
        r_level <= w_sync;
        r_cnt   <= '0;
        r_rise  <= w_sync;
      end else begin
        r_cnt <= r_cnt + DbW'(1);
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/stm_request_conditioner.sv
// Turns debounced STM rising edges into held, acked diode-driver requests with a minimum
// idle gap after each ack, a one-deep pending slot and a sticky overrun flag.
module stm_request_conditioner
  import stm_req_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = DefSyncStages,
  parameter int unsigned DEBOUNCE_CYC = DefDebounceCyc,
  parameter int unsigned MIN_GAP_CYC  = DefMinGapCyc,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_200MHz_i,
  input  logic             reset,
  input  logic             stm_signal,
  input  logic             diods_ack,
  input  logic             overrun_clr,
  output logic             signal_to_diods_request,
  output logic             overrun_flag,
  output logic [CNT_W-1:0] req_count
);

  localparam int unsigned GapW = $clog2(MIN_GAP_CYC + 1);

  req_state_e       r_state, w_state_next;
  logic [GapW-1:0]  r_gap, w_gap_next;
  logic             r_pending, w_pending_next;
  logic             r_overrun, w_overrun_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic             w_event;
  logic             w_gap_done;
  logic             w_queue_event;

  stm_sync_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sync_debounce (
    .i_clk  (clk_200MHz_i),
    .i_reset(reset),
    .i_async(stm_signal),
    .o_rise (w_event)
  );

  // Leaving GAP on the cycle the counter hits zero keeps the request low for exactly
  // MIN_GAP_CYC cycles.
  assign w_gap_done    = (r_state == StGap) && (r_gap == GapW'(1));
  assign w_queue_event = w_event && ((r_state == StReq) || ((r_state == StGap) && !w_gap_done));

  always_comb begin
    w_state_next   = r_state;
    w_gap_next     = r_gap;
    w_pending_next = r_pending;
    w_overrun_next = r_overrun;
    w_count_next   = r_count;

    unique case (r_state)
      StIdle: begin
        if (w_event) w_state_next = StReq;
      end
      StReq: begin
        if (diods_ack) begin
          w_state_next = StGap;
          w_gap_next   = GapW'(MIN_GAP_CYC);
          w_count_next = r_count + CNT_W'(1);
        end
      end
      StGap: begin
        w_gap_next = r_gap - GapW'(1);
        if (w_gap_done) begin
          // An event landing on the expiry cycle either refills the freed slot or is
          // served directly.
          w_state_next   = (r_pending || w_event) ? StReq : StIdle;
          w_pending_next = r_pending && w_event;
        end
      end
      default: w_state_next = StIdle;
    endcase

    if (overrun_clr) w_overrun_next = 1'b0;
    if (w_queue_event) begin
      if (r_pending) w_overrun_next = 1'b1;
      else           w_pending_next = 1'b1;
    end
  end

  always_ff @(posedge clk_200MHz_i) begin
    if (reset) begin
      r_state   <= StIdle;
      r_gap     <= '0;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
      r_count   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_gap     <= w_gap_next;
      r_pending <= w_pending_next;
      r_overrun <= w_overrun_next;
      r_count   <= w_count_next;
    end
  end

  assign signal_to_diods_request = (r_state == StReq);
  assign overrun_flag            = r_overrun;
  assign req_count               = r_count;

endmodule

// File: tb/tb_stm_request_conditioner.sv
// Bench for stm_request_conditioner: directed scenarios plus a randomized run checked
// cycle by cycle against a behavioural model of the request/gap/queue rules.
module tb_stm_request_conditioner;

  localparam int unsigned S     = 2;
  localparam int unsigned D     = 16;
  localparam int unsigned G     = 200;
  localparam int unsigned CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, stm, ack, clr;
  logic             req, ovf;
  logic [CNT_W-1:0] cnt;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit m_hist[$];
  bit m_level, m_ev, m_req, m_q, m_ovf;
  int m_run, m_gap, m_cnt;

  always #5 clk = ~clk;

  stm_request_conditioner #(
    .SYNC_STAGES (S),
    .DEBOUNCE_CYC(D),
    .MIN_GAP_CYC (G),
    .CNT_W       (CNT_W)
  ) u_dut (
    .clk_200MHz_i           (clk),
    .reset                  (rst),
    .stm_signal             (stm),
    .diods_ack              (ack),
    .overrun_clr            (clr),
    .signal_to_diods_request(req),
    .overrun_flag           (ovf),
    .req_count              (cnt)
  );

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    bit seen;
    bit ev_now;
    if (rst) begin
      m_hist = {};
      repeat (S) m_hist.push_back(1'b0);
      m_level = 0; m_run = 0; m_ev = 0;
      m_req = 0; m_gap = 0; m_q = 0; m_ovf = 0; m_cnt = 0;
      return;
    end
    ev_now = m_ev;
    // handshake side
    if (m_req && ack) begin
      m_req = 0;
      m_gap = G;
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (!m_req && m_gap > 0) begin
      m_gap = m_gap - 1;
      if (m_gap == 0 && m_q) begin
        m_req = 1;
        m_q   = 0;
      end
    end
    if (clr) m_ovf = 0;
    if (ev_now) begin
      if (!m_req && m_gap == 0) m_req = 1;
      else if (!m_q)            m_q = 1;
      else                      m_ovf = 1;
    end
    // input side: a change is accepted after D+1 consecutive differing synchronized samples
    seen = m_hist.pop_front();
    m_hist.push_back(stm);
    m_ev = 0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == D + 1) begin
        m_level = seen;
        m_run   = 0;
        m_ev    = seen;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; stm = 0; ack = 0; clr = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    int rise = -1;
    rst = 1; stm = 1; ack = 0; clr = 0;
    step();
    step();
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    checks++;
    if (cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt); end
    rst = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (req === 1'b1 && rise < 0) rise = n;
    end
    checks++;
    if (rise != 19) begin errors++; $display("FAIL reset_high_input_rise: got %0d want 19", rise); end
  endtask

  task automatic test_single_pulse();
    int rise = -1;
    int fall = -1;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      stm = (n < 40);
      ack = (rise >= 0 && n == rise + 3);
      step();
      if (req === 1'b1 && rise < 0) rise = n;
      if (req === 1'b0 && rise >= 0 && fall < 0) fall = n;
    end
    ack = 0;
    checks++;
    if (rise != 19) begin errors++; $display("FAIL single_rise: got %0d want 19", rise); end
    checks++;
    if (fall != 22) begin errors++; $display("FAIL single_fall: got %0d want 22", fall); end
    checks++;
    if (cnt !== 2'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", cnt); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL single_ovf: got %b want 0", ovf); end
  endtask

  task automatic test_glitch();
    int highs = 0;
    do_reset();
    for (int n = 0; n < 80; n++) begin
      stm = (n < 10);
      step();
      if (req !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin errors++; $display("FAIL glitch_req: got %0d high cycles want 0", highs); end
    checks++;
    if (cnt !== 2'd0) begin errors++; $display("FAIL glitch_cnt: got %0d want 0", cnt); end
  endtask

  task automatic test_queued();
    int rises[$];
    int falls[$];
    logic prev = 1'b0;
    do_reset();
    for (int n = 0; n < 260; n++) begin
      stm = (n < 40) || (n >= 60 && n < 100);
      ack = prev;
      step();
      if (req === 1'b1 && !prev) rises.push_back(n);
      if (req === 1'b0 && prev)  falls.push_back(n);
      prev = req;
    end
    ack = 0;
    checks++;
    if (rises.size() != 2) begin
      errors++;
      $display("FAIL queued_rises: got %0d want 2", rises.size());
    end else begin
      checks++;
      if (rises[1] - falls[0] != G) begin
        errors++;
        $display("FAIL queued_gap: got %0d want %0d", rises[1] - falls[0], G);
      end
    end
    checks++;
    if (cnt !== 2'd2) begin errors++; $display("FAIL queued_cnt: got %0d want 2", cnt); end
  endtask

  task automatic test_overrun();
    int rises = 0;
    logic prev = 1'b0;
    do_reset();
    for (int n = 0; n < 700; n++) begin
      stm = (n < 40) || (n >= 80 && n < 120) || (n >= 160 && n < 200);
      ack = (n >= 240) && prev;
      step();
      if (req === 1'b1 && !prev) rises++;
      prev = req;
      if (n == 175) begin
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", ovf); end
      end
      if (n == 185) begin
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovf); end
      end
    end
    ack = 0;
    checks++;
    if (rises != 2) begin errors++; $display("FAIL ovr_requests: got %0d want 2", rises); end
    checks++;
    if (cnt !== 2'd2) begin errors++; $display("FAIL ovr_cnt: got %0d want 2", cnt); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", ovf); end
    clr = 1;
    step();
    clr = 0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", ovf); end
  endtask

  task automatic test_reset_mid();
    int highs = 0;
    logic prev;
    do_reset();
    for (int n = 0; n < 120; n++) begin
      stm = (n < 40) || (n >= 80);
      step();
    end
    checks++;
    if (req !== 1'b1) begin errors++; $display("FAIL rstmid_pre_req: got %b want 1", req); end
    rst = 1; ack = 1; stm = 0;
    step();
    rst = 0; ack = 0;
    checks++;
    if (req !== 1'b0) begin errors++; $display("FAIL rstmid_req: got %b want 0", req); end
    checks++;
    if (cnt !== 2'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d want 0", cnt); end
    prev = req;
    for (int n = 0; n < 300; n++) begin
      ack = prev;
      step();
      if (req !== 1'b0) highs++;
      prev = req;
    end
    ack = 0;
    checks++;
    if (highs != 0) begin errors++; $display("FAIL rstmid_after: got %0d high cycles want 0", highs); end
  endtask

  task automatic test_wrap();
    logic prev = 1'b0;
    logic [CNT_W-1:0] want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      for (int n = 0; n < 260; n++) begin
        stm = (n < 40);
        ack = prev;
        step();
        prev = req;
      end
      want = CNT_W'((k + 1) % 4);
      checks++;
      if (cnt !== want) begin
        errors++;
        $display("FAIL wrap_cnt_%0d: got %0d want %0d", k, cnt, want);
      end
    end
    ack = 0;
  endtask

  task automatic test_random();
    int run_left = 0;
    logic [CNT_W-1:0] exp_cnt;
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (run_left == 0) begin
        stm = ~stm;
        run_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15))
                                               : int'($urandom_range(17, 80));
      end
      run_left--;
      ack = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 63) == 0);
      rst = ($urandom_range(0, 999) == 0);
      step();
      exp_cnt = m_cnt[CNT_W-1:0];
      checks++;
      if (req !== m_req || ovf !== m_ovf || cnt !== exp_cnt) begin
        errors++;
        if (errors < 20)
          $display("FAIL random_cyc_%0d: got req=%b ovf=%b cnt=%0d want req=%b ovf=%b cnt=%0d",
                   n, req, ovf, cnt, m_req, m_ovf, exp_cnt);
      end
    end
    rst = 0; ack = 0; clr = 0; stm = 0;
  endtask

  initial begin
    rst = 1; stm = 0; ack = 0; clr = 0;
    test_reset();
    test_single_pulse();
    test_glitch();
    test_queued();
    test_overrun();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
